// File: rtl/bit_unpacker_pkg.sv
// bit_unpacker shared constants and helpers.
// Width derivations and length clamps used by top and aligner.
package bit_unpacker_pkg;

  function automatic int bufWidth(input int dw);
    return 4 * dw;
  endfunction

  function automatic int cntWidth(input int dw);
    return $clog2(4 * dw) + 1;
  endfunction

  function automatic int clampIn(input int len, input int dw);
    return (len > 2 * dw) ? 2 * dw : len;
  endfunction

  function automatic int clampReq(input int len, input int dw);
    return (len > dw) ? dw : len;
  endfunction

endpackage

// File: rtl/bit_unpacker_field_aligner.sv
// field_aligner: combinational barrel shifter.
// Drops extracted bits off the buffer top and lines up a new word.
module field_aligner
  import bit_unpacker_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_WIDTH  = 128,
  parameter int CW         = 8
) (
  input  logic [BUF_WIDTH-1:0]    buf_i,
  input  logic [CW-1:0]           take_i,
  input  logic [2*DATA_WIDTH-1:0] word_i,
  input  logic [CW-1:0]           pos_i,
  output logic [BUF_WIDTH-1:0]    bufShift_o,
  output logic [BUF_WIDTH-1:0]    wordAligned_o
);

  localparam int PADW = BUF_WIDTH - 2 * DATA_WIDTH;

  logic [BUF_WIDTH-1:0] wordTop;

  assign wordTop = {word_i, {PADW{1'b0}}};

  // both shifts are pure combinational
  always_comb begin
    bufShift_o    = buf_i << take_i;
    wordAligned_o = wordTop >> pos_i;
  end

endmodule

// File: rtl/bit_unpacker.sv
// bit_unpacker top: accumulator, handshakes, output register.
// Fields leave MSB-first; extraction precedes insertion.
module bit_unpacker
  import bit_unpacker_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    inValid,
  input  logic [2*DATA_WIDTH-1:0] inData,
  input  logic [LEN_WIDTH-1:0]    inLen,
  output logic                    inReady,
  input  logic                    reqValid,
  input  logic [LEN_WIDTH-1:0]    reqLen,
  output logic                    reqReady,
  output logic                    outValid,
  output logic [DATA_WIDTH-1:0]   outData,
  output logic [LEN_WIDTH-1:0]    outLen,
  output logic [LEN_WIDTH-1:0]    bitCount
);

  localparam int BUF_WIDTH = bufWidth(DATA_WIDTH);
  localparam int CW        = cntWidth(DATA_WIDTH);
  localparam int WW        = 2 * DATA_WIDTH;

  logic [BUF_WIDTH-1:0]  buf_q, buf_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  outValid_q;
  logic [DATA_WIDTH-1:0] outData_q, outData_d;
  logic [LEN_WIDTH-1:0]  outLen_q, outLen_d;

  logic [CW-1:0]         take, takeEff, inLenC, cntExt;
  logic [WW-1:0]         wordMasked;
  logic [DATA_WIDTH-1:0] field;
  logic [BUF_WIDTH-1:0]  bufShift, wordAligned;
  logic                  reqFire, inFire;

  assign take   = CW'(clampReq(int'(reqLen), DATA_WIDTH));
  assign inLenC = CW'(clampIn(int'(inLen), DATA_WIDTH));

  assign inReady  = int'(count_q) <= (BUF_WIDTH - WW);
  assign reqReady = int'(count_q) >= int'(reqLen);

  assign reqFire = reqValid && reqReady && !flush;
  assign inFire  = inValid && inReady && !flush;

  assign takeEff    = reqFire ? take : '0;
  assign cntExt     = count_q - takeEff;
  assign wordMasked = inData & ~({WW{1'b1}} >> inLenC);
  assign field      = buf_q[BUF_WIDTH-1 -: DATA_WIDTH]
                    & ~({DATA_WIDTH{1'b1}} >> take);

  field_aligner #(
    .DATA_WIDTH(DATA_WIDTH),
    .BUF_WIDTH (BUF_WIDTH),
    .CW        (CW)
  ) u_aligner (
    .buf_i        (buf_q),
    .take_i       (takeEff),
    .word_i       (wordMasked),
    .pos_i        (cntExt),
    .bufShift_o   (bufShift),
    .wordAligned_o(wordAligned)
  );

  // next state: extract, then merge the new word at the reduced count
  always_comb begin
    buf_d     = bufShift | (inFire ? wordAligned : '0);
    count_d   = cntExt + (inFire ? inLenC : '0);
    outData_d = outData_q;
    outLen_d  = outLen_q;
    if (reqFire) begin
      outData_d = field;
      outLen_d  = LEN_WIDTH'(take);
    end
  end

  // state and output registers; flush clears bits but keeps last field
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q      <= '0;
      count_q    <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outLen_q   <= '0;
    end else if (flush) begin
      buf_q      <= '0;
      count_q    <= '0;
      outValid_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      count_q    <= count_d;
      outValid_q <= reqFire;
      outData_q  <= outData_d;
      outLen_q   <= outLen_d;
    end
  end

  assign outValid = outValid_q;
  assign outData  = outData_q;
  assign outLen   = outLen_q;
  assign bitCount = LEN_WIDTH'(count_q);

endmodule

// File: tb/tb_bit_unpacker.sv
// bit_unpacker bench: bit-queue model plus directed vectors.
// Model checked every negedge; literal checks pin known fields.
module tb_bit_unpacker;

  logic        clk = 1'b0;
  logic        reset, flush, inValid, reqValid;
  logic [63:0] inData;
  logic [7:0]  inLen, reqLen;
  logic        inReady, reqReady, outValid;
  logic [31:0] outData;
  logic [7:0]  outLen, bitCount;

  int vectors = 0;
  int miscompares = 0;

  bit          q[$];
  bit          started = 1'b0;
  bit          eOV;
  logic [31:0] eOD;
  logic [7:0]  eOL;

  always #5 clk = ~clk;

  bit_unpacker dut (
    .clk(clk), .reset(reset), .flush(flush),
    .inValid(inValid), .inData(inData), .inLen(inLen),
    .inReady(inReady),
    .reqValid(reqValid), .reqLen(reqLen), .reqReady(reqReady),
    .outValid(outValid), .outData(outData), .outLen(outLen),
    .bitCount(bitCount)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: bits live in a FIFO, oldest first
  always @(posedge clk) begin
    bit rr, ir;
    int take, n;
    logic [31:0] d;
    if (reset) begin
      q.delete();
      eOV = 0; eOD = '0; eOL = '0;
      started = 1'b1;
    end else begin
      rr = q.size() >= int'(reqLen);
      ir = q.size() <= 64;
      eOV = 0;
      if (flush) begin
        q.delete();
      end else begin
        if (reqValid && rr) begin
          take = (reqLen > 32) ? 32 : int'(reqLen);
          d = '0;
          for (int i = 0; i < take; i++) d[31-i] = q.pop_front();
          eOD = d; eOL = 8'(take); eOV = 1;
        end
        if (inValid && ir) begin
          n = (inLen > 64) ? 64 : int'(inLen);
          for (int i = 0; i < n; i++) q.push_back(inData[63-i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_outValid", 64'(outValid), 64'(eOV));
      chk("m_outData", 64'(outData), 64'(eOD));
      chk("m_outLen", 64'(outLen), 64'(eOL));
      chk("m_bitCount", 64'(bitCount), 64'(q.size()));
      chk("m_inReady", 64'(inReady), 64'(q.size() <= 64));
      chk("m_reqReady", 64'(reqReady), 64'(q.size() >= int'(reqLen)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inValid = 0; reqValid = 0; flush = 0;
    inData = '0; inLen = '0; reqLen = '0;
  endtask

  task automatic push(input logic [63:0] d, input logic [7:0] l);
    idle(); inValid = 1; inData = d; inLen = l;
    tick(); idle();
  endtask

  task automatic req(input logic [7:0] l);
    idle(); reqValid = 1; reqLen = l;
    tick(); idle();
  endtask

  task automatic field(input string nm, input logic [31:0] d,
                       input logic [7:0] l, input logic [7:0] bc);
    chk({nm, "_v"}, 64'(outValid), 64'd1);
    chk({nm, "_d"}, 64'(outData), 64'(d));
    chk({nm, "_l"}, 64'(outLen), 64'(l));
    chk({nm, "_bc"}, 64'(bitCount), 64'(bc));
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    chk("rst_outValid", 64'(outValid), 64'd0);
    chk("rst_outData", 64'(outData), 64'd0);
    chk("rst_outLen", 64'(outLen), 64'd0);
    chk("rst_bitCount", 64'(bitCount), 64'd0);
    chk("rst_inReady", 64'(inReady), 64'd1);
    chk("rst_reqReady0", 64'(reqReady), 64'd1);
    reqValid = 1; reqLen = 8'd5; #1;
    chk("rst_reqReady5", 64'(reqReady), 64'd0);
    idle(); tick();

    push(64'hABCD_0000_0000_0000, 8'd16);
    chk("p16_bc", 64'(bitCount), 64'd16);
    req(8'd8);  field("ab", 32'hAB00_0000, 8'd8, 8'd8);
    req(8'd8);  field("cd", 32'hCD00_0000, 8'd8, 8'd0);
    tick();
    chk("idle_ov", 64'(outValid), 64'd0);
    chk("hold_od", 64'(outData), 64'hCD00_0000);

    push(64'h3C00_0000_0000_0000, 8'd8);
    reqValid = 1; reqLen = 8'd12; #1;
    chk("starve_rr", 64'(reqReady), 64'd0);
    inValid = 1; inData = 64'hF0 << 56; inLen = 8'd8;
    tick();
    inValid = 0; inData = '0; inLen = '0; #1;
    chk("starve_ov", 64'(outValid), 64'd0);
    chk("starve_rr2", 64'(reqReady), 64'd1);
    tick(); idle();
    field("starve", 32'h3CF0_0000, 8'd12, 8'd4);
    req(8'd4);  field("drain4", 32'h0, 8'd4, 8'd0);

    push(64'h0123_4567_89AB_CDEF, 8'd64);
    chk("f1_ir", 64'(inReady), 64'd1);
    push(64'hFEDC_BA98_7654_3210, 8'd64);
    chk("f2_bc", 64'(bitCount), 64'd128);
    chk("f2_ir", 64'(inReady), 64'd0);
    push(64'hFFFF_FFFF_FFFF_FFFF, 8'd64);
    chk("f3_bc", 64'(bitCount), 64'd128);
    req(8'd32); field("f_a", 32'h0123_4567, 8'd32, 8'd96);
    chk("f_a_ir", 64'(inReady), 64'd0);
    req(8'd32); field("f_b", 32'h89AB_CDEF, 8'd32, 8'd64);
    chk("f_b_ir", 64'(inReady), 64'd1);
    req(8'd32); field("f_c", 32'hFEDC_BA98, 8'd32, 8'd32);
    req(8'd32); field("f_d", 32'h7654_3210, 8'd32, 8'd0);

    push(64'hA5 << 56, 8'd8);
    idle();
    inValid = 1; inData = 64'h1234 << 48; inLen = 8'd16;
    reqValid = 1; reqLen = 8'd8;
    tick(); idle();
    field("sim", 32'hA500_0000, 8'd8, 8'd16);
    req(8'd16); field("sim2", 32'h1234_0000, 8'd16, 8'd0);

    push(64'hDEAD_BEEF_CAFE_F00D, 8'd200);
    chk("clamp_in_bc", 64'(bitCount), 64'd64);
    req(8'd40); field("clamp_req", 32'hDEAD_BEEF, 8'd32, 8'd32);
    req(8'd0);  field("zero_req", 32'h0, 8'd0, 8'd32);
    push(64'hFFFF_0000_0000_0000, 8'd0);
    chk("zero_in_bc", 64'(bitCount), 64'd32);
    idle(); flush = 1; reqValid = 1; reqLen = 8'd8;
    inValid = 1; inData = '1; inLen = 8'd8;
    tick(); idle();
    chk("flush_ov", 64'(outValid), 64'd0);
    chk("flush_bc", 64'(bitCount), 64'd0);
    chk("flush_ol", 64'(outLen), 64'd0);
    req(8'd0);  field("zero_at0", 32'h0, 8'd0, 8'd0);
    push(64'h81FF_FFFF_FFFF_FFFF, 8'd8);
    req(8'd8);  field("mask", 32'h8100_0000, 8'd8, 8'd0);

    push(64'hFF00_0000_0000_0000, 8'd8);
    reset = 1; tick(); reset = 0;
    push(64'h6000_0000_0000_0000, 8'd3);
    req(8'd3);  field("rst_mid", 32'h6000_0000, 8'd3, 8'd0);

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
